// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - bubble-sort sequencer driving one shared external 4-bit comparator
// Loads N samples, sorts them ascending one compare per cycle, and exposes a combinational read port.
module cmp_sort_ctrl #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       start,
  input  logic       clear,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] swap_count,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [3:0] cmp_a,
  output logic [3:0] cmp_b,
  input  logic       cmp_less,
  input  logic       cmp_equal,
  input  logic       cmp_greater
);

  localparam int AW = $clog2(N);
  localparam logic [4:0]    FILL_FULL = 5'(N);
  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 2);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SWAP,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    mem [N];
  logic [4:0]    fill;
  logic [AW-1:0] i;
  logic [AW-1:0] pass;
  logic          swapped;

  logic [AW-1:0] i_next;
  logic          one_hot;
  logic          pass_end;
  logic          swapped_post;
  logic          sort_finished;

  assign i_next  = i + IDX_ONE;
  assign one_hot = (cmp_less + cmp_equal + cmp_greater) == 2'd1;

  // End-of-pass decision uses the swapped flag as it will be after this cycle's SWAP.
  assign pass_end      = (i == LAST_IDX);
  assign swapped_post  = (state == SWAP) || swapped;
  assign sort_finished = !swapped_post || (pass == LAST_IDX);

  assign in_ready = (state == IDLE) && (fill < FILL_FULL);
  assign busy     = (state == CMP) || (state == SWAP);
  assign done     = (state == DONE);
  assign cmp_a    = busy ? mem[i] : 4'd0;
  assign cmp_b    = busy ? mem[i_next] : 4'd0;
  assign rd_data  = ({1'b0, rd_addr} < FILL_FULL) ? mem[rd_addr[AW-1:0]] : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fill       <= '0;
      i          <= '0;
      pass       <= '0;
      swapped    <= 1'b0;
      err        <= 1'b0;
      swap_count <= '0;
      for (int k = 0; k < N; k++) begin
        mem[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            fill <= '0;
            err  <= 1'b0;
          end else begin
            if (in_valid && in_ready) begin
              mem[fill[AW-1:0]] <= in_data;
              fill              <= fill + 5'd1;
            end
            if (start && (fill == FILL_FULL)) begin
              state      <= CMP;
              i          <= '0;
              pass       <= '0;
              swapped    <= 1'b0;
              swap_count <= '0;
            end
          end
        end

        CMP, SWAP: begin
          if (state == SWAP) begin
            mem[i]      <= mem[i_next];
            mem[i_next] <= mem[i];
            swap_count  <= swap_count + 8'd1;
            swapped     <= 1'b1;
          end else if (!one_hot) begin
            err <= 1'b1;
          end

          // A malformed comparator result is treated as "no swap".
          if ((state == CMP) && one_hot && cmp_greater) begin
            state <= SWAP;
          end else if (!pass_end) begin
            i     <= i_next;
            state <= CMP;
          end else if (sort_finished) begin
            state <= DONE;
          end else begin
            pass    <= pass + IDX_ONE;
            i       <= '0;
            swapped <= 1'b0;
            state   <= CMP;
          end
        end

        DONE: begin
          if (clear) begin
            state <= IDLE;
            fill  <= '0;
            err   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb/tb_cmp_sort_ctrl.sv - directed self-checking bench for cmp_sort_ctrl
module tb_cmp_sort_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       start;
  logic       clear;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] swap_count;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       cmp_less;
  logic       cmp_equal;
  logic       cmp_greater;
  logic       force_bad;

  int checks;
  int errors;

  cmp_sort_ctrl #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .clear      (clear),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .swap_count (swap_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_less   (cmp_less),
    .cmp_equal  (cmp_equal),
    .cmp_greater(cmp_greater)
  );

  // External comparator model, with an override that produces a non-one-hot result.
  assign cmp_less    = force_bad ? 1'b1 : (cmp_a < cmp_b);
  assign cmp_equal   = force_bad ? 1'b1 : (cmp_a == cmp_b);
  assign cmp_greater = force_bad ? 1'b0 : (cmp_a > cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load(input logic [3:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clear_buf();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Pulses start and counts busy cycles until done, bounded.
  task automatic run_sort(output int cycles, output logic timed_out);
    int budget;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    budget = 0;
    while (!done && budget < 100) begin
      if (busy) cycles++;
      budget++;
      @(negedge clk);
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b err=%b required 0 0 0", busy, done, err);
    end
    checks++;
    if (swap_count !== 8'd0 || in_ready !== 1'b1 || cmp_a !== 4'd0 || cmp_b !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs swap_count=%0d in_ready=%b cmp_a=%0d cmp_b=%0d required 0 1 0 0",
               swap_count, in_ready, cmp_a, cmp_b);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 4'(k);
      #1;
      checks++;
      if (rd_data !== 4'd0) begin
        errors++;
        $display("FAIL reset_mem[%0d] got %0d required 0", k, rd_data);
      end
    end
  endtask

  task automatic test_reverse();
    logic [3:0] exp [4];
    int cycles;
    logic to;
    exp = '{4'd3, 4'd10, 4'd12, 4'd15};
    load(4'd15); load(4'd12); load(4'd10); load(4'd3);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reverse_full_ready got %b required 0", in_ready);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cmp_a !== 4'd15 || cmp_b !== 4'd12) begin
      errors++;
      $display("FAIL reverse_first_cmp busy=%b a=%0d b=%0d required 1 15 12", busy, cmp_a, cmp_b);
    end
    cycles = 0;
    to = 1'b1;
    for (int b = 0; b < 100; b++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) cycles++;
      @(negedge clk);
    end
    checks++;
    if (to || cycles != 15) begin
      errors++;
      $display("FAIL reverse_busy_cycles got %0d timeout=%b required 15", cycles, to);
    end
    checks++;
    if (swap_count !== 8'd6 || err !== 1'b0 || cmp_a !== 4'd0) begin
      errors++;
      $display("FAIL reverse_status swaps=%0d err=%b cmp_a=%0d required 6 0 0", swap_count, err, cmp_a);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 4'(k);
      #1;
      checks++;
      if (rd_data !== exp[k]) begin
        errors++;
        $display("FAIL reverse_data[%0d] got %0d required %0d", k, rd_data, exp[k]);
      end
    end
    clear_buf();
  endtask

  task automatic test_sorted();
    logic [3:0] exp [4];
    int cycles;
    logic to;
    exp = '{4'd3, 4'd10, 4'd12, 4'd15};
    load(4'd3); load(4'd10); load(4'd12); load(4'd15);
    run_sort(cycles, to);
    checks++;
    if (to || cycles != 3 || swap_count !== 8'd0) begin
      errors++;
      $display("FAIL sorted_run cycles=%0d swaps=%0d timeout=%b required 3 0", cycles, swap_count, to);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 4'(k);
      #1;
      checks++;
      if (rd_data !== exp[k]) begin
        errors++;
        $display("FAIL sorted_data[%0d] got %0d required %0d", k, rd_data, exp[k]);
      end
    end
    clear_buf();
  endtask

  task automatic test_equal();
    logic [3:0] exp [4];
    int cycles;
    logic to;
    exp = '{4'd10, 4'd10, 4'd11, 4'd12};
    load(4'd10); load(4'd10); load(4'd12); load(4'd11);
    run_sort(cycles, to);
    checks++;
    if (to || cycles != 7 || swap_count !== 8'd1) begin
      errors++;
      $display("FAIL equal_run cycles=%0d swaps=%0d timeout=%b required 7 1", cycles, swap_count, to);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 4'(k);
      #1;
      checks++;
      if (rd_data !== exp[k]) begin
        errors++;
        $display("FAIL equal_data[%0d] got %0d required %0d", k, rd_data, exp[k]);
      end
    end
    clear_buf();
  endtask

  task automatic test_partial();
    logic [3:0] exp [5];
    exp = '{4'd5, 4'd1, 4'd9, 4'd2, 4'd0};
    load(4'd5); load(4'd1); load(4'd9);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL partial_start busy=%b done=%b in_ready=%b required 0 0 1", busy, done, in_ready);
    end
    load(4'd2);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL partial_full_ready got %b required 0", in_ready);
    end
    load(4'd7);
    for (int k = 0; k < 5; k++) begin
      rd_addr = 4'(k);
      #1;
      checks++;
      if (rd_data !== exp[k]) begin
        errors++;
        $display("FAIL partial_data[%0d] got %0d required %0d", k, rd_data, exp[k]);
      end
    end
    rd_addr = 4'd15;
    #1;
    checks++;
    if (rd_data !== 4'd0) begin
      errors++;
      $display("FAIL partial_oob_read got %0d required 0", rd_data);
    end
    // clear and start together: clear takes priority
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_start busy=%b in_ready=%b required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp [4];
    int cycles;
    logic to;
    exp = '{4'd1, 4'd2, 4'd4, 4'd8};
    load(4'd15); load(4'd12); load(4'd10); load(4'd3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || swap_count !== 8'd0 ||
        in_ready !== 1'b1 || cmp_a !== 4'd0 || cmp_b !== 4'd0) begin
      errors++;
      $display("FAIL midreset_outputs busy=%b done=%b err=%b swaps=%0d in_ready=%b a=%0d b=%0d required 0 0 0 0 1 0 0",
               busy, done, err, swap_count, in_ready, cmp_a, cmp_b);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 4'(k);
      #1;
      checks++;
      if (rd_data !== 4'd0) begin
        errors++;
        $display("FAIL midreset_mem[%0d] got %0d required 0", k, rd_data);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    load(4'd4); load(4'd2); load(4'd8); load(4'd1);
    run_sort(cycles, to);
    checks++;
    if (to || cycles != 13 || swap_count !== 8'd4) begin
      errors++;
      $display("FAIL midreset_resort cycles=%0d swaps=%0d timeout=%b required 13 4", cycles, swap_count, to);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 4'(k);
      #1;
      checks++;
      if (rd_data !== exp[k]) begin
        errors++;
        $display("FAIL midreset_data[%0d] got %0d required %0d", k, rd_data, exp[k]);
      end
    end
    clear_buf();
  endtask

  task automatic test_err();
    int budget;
    load(4'd1); load(4'd2); load(4'd3); load(4'd4);
    @(negedge clk);
    start     = 1'b1;
    force_bad = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    force_bad = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_set err=%b busy=%b required 1 1", err, busy);
    end
    budget = 0;
    while (!done && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || swap_count !== 8'd0) begin
      errors++;
      $display("FAIL err_done done=%b err=%b swaps=%0d required 1 1 0", done, err, swap_count);
    end
    rd_addr = 4'd3;
    #1;
    checks++;
    if (rd_data !== 4'd4) begin
      errors++;
      $display("FAIL err_data3 got %0d required 4", rd_data);
    end
    clear_buf();
    checks++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_clear err=%b done=%b busy=%b in_ready=%b required 0 0 0 1",
               err, done, busy, in_ready);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    start     = 1'b0;
    clear     = 1'b0;
    rd_addr   = 4'd0;
    force_bad = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_reverse();
    test_sorted();
    test_equal();
    test_partial();
    test_mid_reset();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
